dmem_responder: RTL

Data-memory responder at the far end of the CPU's dmem interface. It answers the core's combinational read/write port: dmem_addr, dmem_w_en and dmem_wdata in, dmem_rdata out. After reset it self-clears its storage, and it also serves a valid/ready host port that testbench or loader logic uses to preload and inspect memory. It sits beside the cpu top level, outside the pipeline.

---
 rtl/dmem_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU dmem port, with a post-reset clear and a valid/ready host port.
// Optional access counters are enabled by defining DMEM_ACCESS_CNT_EN.
module dmem_responder #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_w_en,
  input  logic [WIDTH-1:0]  dmem_wdata,
  output logic [WIDTH-1:0]  dmem_rdata,
  output logic              init_busy,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_req_wr,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [WIDTH-1:0]  host_req_wdata,
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic [WIDTH-1:0]  host_rsp_rdata,
  output logic              host_rsp_coll
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0]       cpu_wr_cnt,
  output logic [31:0]       host_acc_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_READY = 2'd1,
    ST_RSP   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic                accept_s;
  logic                cpu_we_s;
  logic                same_addr_s;
  logic                coll_s;
  logic                host_we_s;

  assign accept_s    = host_req_valid & host_req_ready;
  assign cpu_we_s    = dmem_w_en & (state_r != ST_CLEAR) & ~reset;
  assign same_addr_s = (dmem_addr == host_req_addr);
  // On a same-address write collision the CPU write wins and the host write is dropped.
  assign coll_s      = accept_s & host_req_wr & cpu_we_s & same_addr_s;
  assign host_we_s   = accept_s & host_req_wr & ~coll_s;
  assign dmem_rdata  = init_busy ? {WIDTH{1'b0}} : mem_r[dmem_addr];

  // State register and clear counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_cnt_r <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_CLEAR) begin
        clr_cnt_r <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        clr_cnt_r <= {ADDR_W{1'b0}};
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == ADDR_W'(DEPTH - 1)) state_nxt_s = ST_READY;
        else                                 state_nxt_s = ST_CLEAR;
      end
      ST_READY: begin
        if (host_req_valid) state_nxt_s = ST_RSP;
        else                state_nxt_s = ST_READY;
      end
      ST_RSP: begin
        if (host_rsp_ready) state_nxt_s = ST_READY;
        else                state_nxt_s = ST_RSP;
      end
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // State-decoded outputs; reset holds the block busy and refuses new requests
  always_comb begin
    init_busy      = 1'b0;
    host_req_ready = 1'b0;
    host_rsp_valid = 1'b0;
    case (state_r)
      ST_CLEAR: init_busy      = 1'b1;
      ST_READY: host_req_ready = ~reset;
      ST_RSP:   host_rsp_valid = 1'b1;
      default:  init_busy      = 1'b1;
    endcase
    if (reset) init_busy = 1'b1;
    else       init_busy = init_busy;
  end

  // Storage: cleared word by word in CLEAR, otherwise CPU and host writes
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_cnt_r] <= {WIDTH{1'b0}};
    end else begin
      if (cpu_we_s)  mem_r[dmem_addr]     <= dmem_wdata;
      if (host_we_s) mem_r[host_req_addr] <= host_req_wdata;
    end
  end

  // Response payload captured on accept (read-before-write), held until the next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      host_rsp_rdata <= {WIDTH{1'b0}};
      host_rsp_coll  <= 1'b0;
    end else if (accept_s) begin
      host_rsp_rdata <= mem_r[host_req_addr];
      host_rsp_coll  <= coll_s;
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  // Saturating access counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_wr_cnt   <= 32'd0;
      host_acc_cnt <= 32'd0;
    end else begin
      if (cpu_we_s && (cpu_wr_cnt != 32'hFFFF_FFFF))   cpu_wr_cnt   <= cpu_wr_cnt + 32'd1;
      if (accept_s && (host_acc_cnt != 32'hFFFF_FFFF)) host_acc_cnt <= host_acc_cnt + 32'd1;
    end
  end
`endif

endmodule
